// File: rtl/vredsum_seq_unit.sv
// Sequential vector reduction (sum/max/min, signed or unsigned, SEW 8/16/32) over a vs2 register group.
// Latency: one vs2 register per cycle; out_valid rises nregs edges after the accept edge.
// Backpressure: in_ready only in IDLE; the result is held in DONE until out_ready.
module vredsum_seq_unit #(
    parameter int VLEN_BITS     = 128,
    parameter int MAX_LMUL_LOG2 = 2,
    parameter int VL_W          = $clog2(VLEN_BITS * (1 << MAX_LMUL_LOG2) / 8) + 1
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      in_valid,
    output logic                                      in_ready,
    input  logic [1:0]                                sew,
    input  logic [1:0]                                lmul_log2,
    input  logic [1:0]                                op,
    input  logic                                      is_signed,
    input  logic [VL_W-1:0]                           vl,
    input  logic [VLEN_BITS*(1<<MAX_LMUL_LOG2)-1:0]   vs2_bus,
    input  logic [VLEN_BITS-1:0]                      vs1_bus,
    input  logic [VLEN_BITS-1:0]                      vd_old,
    output logic                                      out_valid,
    input  logic                                      out_ready,
    output logic [VLEN_BITS-1:0]                      vd_bus,
    output logic                                      err
);

    localparam int GRP_BITS = VLEN_BITS * (1 << MAX_LMUL_LOG2);
    localparam int EPR8     = VLEN_BITS / 8;
    localparam int RW       = (MAX_LMUL_LOG2 > 0) ? MAX_LMUL_LOG2 : 1;

    typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

    state_t                state_q, state_d;
    logic [1:0]            sew_q, sew_d;
    logic [1:0]            op_q, op_d;
    logic                  sgn_q, sgn_d;
    logic                  err_q, err_d;
    logic [VL_W-1:0]       vl_q, vl_d;
    logic [GRP_BITS-1:0]   vs2_q, vs2_d;
    logic [VLEN_BITS-1:0]  vd_old_q, vd_old_d;
    logic [VLEN_BITS-1:0]  vd_q, vd_d;
    logic [31:0]           acc_q, acc_d;
    logic [RW-1:0]         r_q, r_d;
    logic [RW-1:0]         last_q, last_d;

    logic [VLEN_BITS-1:0]  reg_sel;
    logic [31:0]           elem [EPR8];
    logic [31:0]           red_acc;
    logic                  illegal;
    int                    vlmax;
    int                    epr;
    int                    base;
    logic                  unused_vs1;

    assign unused_vs1 = ^vs1_bus[VLEN_BITS-1:32];

    function automatic logic [31:0] ext_elem(input logic [31:0] raw, input logic [1:0] w, input logic sg);
        logic [31:0] r;
        case (w)
            2'd0:    r = {{24{sg & raw[7]}}, raw[7:0]};
            2'd1:    r = {{16{sg & raw[15]}}, raw[15:0]};
            default: r = raw;
        endcase
        return r;
    endfunction

    function automatic logic gt(input logic [31:0] a, input logic [31:0] b, input logic sg);
        return sg ? ($signed(a) > $signed(b)) : (a > b);
    endfunction

    function automatic logic [VLEN_BITS-1:0] merge(input logic [VLEN_BITS-1:0] old,
                                                   input logic [31:0] res, input logic [1:0] w);
        logic [VLEN_BITS-1:0] r;
        r = old;
        case (w)
            2'd0:    r[7:0]  = res[7:0];
            2'd1:    r[15:0] = res[15:0];
            2'd2:    r[31:0] = res;
            default: r = old;
        endcase
        return r;
    endfunction

    // Extended lanes of the current register; lanes past VLEN/SEW stay zero and are never active.
    always_comb begin
        reg_sel = vs2_q[int'(r_q) * VLEN_BITS +: VLEN_BITS];
        for (int k = 0; k < EPR8; k++) elem[k] = '0;
        case (sew_q)
            2'd0: for (int k = 0; k < EPR8; k++)
                      elem[k] = ext_elem({24'b0, reg_sel[k*8 +: 8]}, 2'd0, sgn_q);
            2'd1: for (int k = 0; k < EPR8 / 2; k++)
                      elem[k] = ext_elem({16'b0, reg_sel[k*16 +: 16]}, 2'd1, sgn_q);
            default: for (int k = 0; k < EPR8 / 4; k++)
                      elem[k] = reg_sel[k*32 +: 32];
        endcase
    end

    always_comb begin
        red_acc = acc_q;
        epr     = EPR8 >> sew_q;
        base    = int'(r_q) * epr;
        for (int k = 0; k < EPR8; k++) begin
            if (k < epr && (base + k) < int'(vl_q)) begin
                case (op_q)
                    2'd0:    red_acc = red_acc + elem[k];
                    2'd1:    if (gt(elem[k], red_acc, sgn_q)) red_acc = elem[k];
                    2'd2:    if (gt(red_acc, elem[k], sgn_q)) red_acc = elem[k];
                    default: red_acc = red_acc;
                endcase
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        sew_d    = sew_q;
        op_d     = op_q;
        sgn_d    = sgn_q;
        err_d    = err_q;
        vl_d     = vl_q;
        vs2_d    = vs2_q;
        vd_old_d = vd_old_q;
        vd_d     = vd_q;
        acc_d    = acc_q;
        r_d      = r_q;
        last_d   = last_q;
        in_ready = (state_q == IDLE);
        illegal  = (sew == 2'd3) || (op == 2'd3) || (int'(lmul_log2) > MAX_LMUL_LOG2);
        vlmax    = illegal ? 0 : ((EPR8 << lmul_log2) >> sew);

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d  = ACC;
                    sew_d    = sew;
                    op_d     = op;
                    sgn_d    = is_signed;
                    err_d    = illegal;
                    vl_d     = (int'(vl) > vlmax) ? VL_W'(vlmax) : vl;
                    vs2_d    = vs2_bus;
                    vd_old_d = vd_old;
                    acc_d    = ext_elem(vs1_bus[31:0], sew, is_signed);
                    r_d      = '0;
                    last_d   = illegal ? '0 : RW'((1 << lmul_log2) - 1);
                end
            end
            ACC: begin
                if (!err_q) acc_d = red_acc;
                r_d = r_q + RW'(1);
                if (r_q == last_q) begin
                    state_d = DONE;
                    vd_d    = err_q ? vd_old_q : merge(vd_old_q, red_acc, sew_q);
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            sew_q    <= '0;
            op_q     <= '0;
            sgn_q    <= 1'b0;
            err_q    <= 1'b0;
            vl_q     <= '0;
            vs2_q    <= '0;
            vd_old_q <= '0;
            vd_q     <= '0;
            acc_q    <= '0;
            r_q      <= '0;
            last_q   <= '0;
        end else begin
            state_q  <= state_d;
            sew_q    <= sew_d;
            op_q     <= op_d;
            sgn_q    <= sgn_d;
            err_q    <= err_d;
            vl_q     <= vl_d;
            vs2_q    <= vs2_d;
            vd_old_q <= vd_old_d;
            vd_q     <= vd_d;
            acc_q    <= acc_d;
            r_q      <= r_d;
            last_q   <= last_d;
        end
    end

    assign out_valid = (state_q == DONE);
    assign vd_bus    = vd_q;
    assign err       = err_q;

endmodule

// File: tb/tb_vredsum_seq_unit.sv
// Scoreboard bench for vredsum_seq_unit: driver pushes reference results, monitor checks each output.
module tb_vredsum_seq_unit;

    localparam int VLEN = 128;
    localparam int MAXL = 2;
    localparam int GRP  = VLEN * (1 << MAXL);
    localparam int VL_W = $clog2(GRP / 8) + 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [1:0]       sew = '0, lmul_log2 = '0, op = '0;
    logic             is_signed = 1'b0;
    logic [VL_W-1:0]  vl = '0;
    logic [GRP-1:0]   vs2_bus = '0;
    logic [VLEN-1:0]  vs1_bus = '0, vd_old = '0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [VLEN-1:0]  vd_bus;
    logic             err;

    vredsum_seq_unit #(.VLEN_BITS(VLEN), .MAX_LMUL_LOG2(MAXL)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .sew(sew), .lmul_log2(lmul_log2), .op(op), .is_signed(is_signed), .vl(vl),
        .vs2_bus(vs2_bus), .vs1_bus(vs1_bus), .vd_old(vd_old),
        .out_valid(out_valid), .out_ready(out_ready), .vd_bus(vd_bus), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [VLEN-1:0] vd;
        logic            er;
        int              nregs;
        int              acc_cyc;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    bit   rand_ready = 1'b0;
    bit   force_ready = 1'b1;
    logic ov_prev = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) out_ready = rand_ready ? 1'($urandom_range(0, 1)) : force_ready;

    task automatic chk(input string name, input logic [VLEN-1:0] act, input logic [VLEN-1:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    // Element idx of width w taken from a flat bus, optionally as a signed integer.
    function automatic longint getval(input logic [GRP-1:0] x, input int idx, input int w, input bit sg);
        logic [GRP-1:0] t;
        longint u;
        t = x >> (idx * w);
        u = longint'(t[31:0]) & ((longint'(1) << w) - 1);
        if (sg && ((u >> (w - 1)) & 1) == 1) u = u - (longint'(1) << w);
        return u;
    endfunction

    function automatic void model(input logic [1:0] s, input logic [1:0] l, input logic [1:0] o,
                                  input logic sg, input logic [VL_W-1:0] v, input logic [GRP-1:0] b2,
                                  input logic [VLEN-1:0] b1, input logic [VLEN-1:0] bo,
                                  output logic [VLEN-1:0] vd, output logic er, output int nr);
        int w, n;
        longint acc, x, res;
        bit cmp_sg;
        if (s == 2'd3 || o == 2'd3 || int'(l) > MAXL) begin
            vd = bo; er = 1'b1; nr = 1;
            return;
        end
        w = 8 << s;
        nr = 1 << l;
        n = nr * VLEN / w;
        if (int'(v) < n) n = int'(v);
        cmp_sg = sg && (o != 2'd0);
        acc = getval({{(GRP-VLEN){1'b0}}, b1}, 0, w, cmp_sg);
        for (int i = 0; i < n; i++) begin
            x = getval(b2, i, w, cmp_sg);
            if (o == 2'd0) acc = acc + x;
            else if (o == 2'd1 && x > acc) acc = x;
            else if (o == 2'd2 && x < acc) acc = x;
        end
        res = acc & ((longint'(1) << w) - 1);
        vd = bo;
        for (int b = 0; b < w; b++) vd[b] = res[b];
        er = 1'b0;
    endfunction

    function automatic logic [GRP-1:0] rand_grp();
        logic [GRP-1:0] r;
        for (int i = 0; i < GRP / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // Checks every cycle the result is presented; pops on handshake.
    always @(negedge clk) begin
        #2;
        if (rst) begin
            ov_prev = 1'b0;
        end else begin
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_output: got out_valid=1 with vd_bus=%h, expected no pending result", vd_bus);
                end else begin
                    if (!ov_prev) chk("latency", VLEN'(cyc - exp_q[0].acc_cyc), VLEN'(exp_q[0].nregs));
                    chk("vd_bus", vd_bus, exp_q[0].vd);
                    chk("err", VLEN'(err), VLEN'(exp_q[0].er));
                    chk("in_ready_busy", VLEN'(in_ready), '0);
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
            ov_prev = out_valid;
        end
    end

    task automatic issue(input logic [1:0] s, input logic [1:0] l, input logic [1:0] o, input logic sg,
                         input logic [VL_W-1:0] v, input logic [GRP-1:0] b2,
                         input logic [VLEN-1:0] b1, input logic [VLEN-1:0] bo);
        exp_t e;
        int t;
        @(negedge clk);
        sew = s; lmul_log2 = l; op = o; is_signed = sg; vl = v;
        vs2_bus = b2; vs1_bus = b1; vd_old = bo;
        in_valid = 1'b1;
        t = 0;
        while (!in_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout: in_ready=0 after %0d cycles, expected 1", t);
            in_valid = 1'b0;
            return;
        end
        model(s, l, o, sg, v, b2, b1, bo, e.vd, e.er, e.nregs);
        e.acc_cyc = cyc + 1;
        exp_q.push_back(e);
        @(negedge clk);
        in_valid = 1'b0;
        sew = 2'($urandom); lmul_log2 = 2'($urandom); op = 2'($urandom); is_signed = 1'($urandom);
        vl = VL_W'($urandom);
        vs2_bus = rand_grp(); vs1_bus = rand_grp()[VLEN-1:0]; vd_old = rand_grp()[VLEN-1:0];
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout: %0d results still pending, expected 0", exp_q.size());
            exp_q.delete();
        end
        @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        logic [GRP-1:0]  b2;
        logic [VLEN-1:0] aa;
        int t;

        aa = {16{8'hAA}};
        repeat (3) @(negedge clk);
        chk("rst_out_valid", VLEN'(out_valid), '0);
        chk("rst_vd_bus", vd_bus, '0);
        chk("rst_err", VLEN'(err), '0);
        rst = 1'b0;
        #1;
        chk("rst_in_ready", VLEN'(in_ready), VLEN'(1));

        // Byte sum of sixteen ones seeded with 5.
        issue(2'd0, 2'd0, 2'd0, 1'b0, VL_W'(16), {64{8'h01}}, VLEN'(8'h05), aa);
        drain();

        // 32-bit sum over a four-register group, element i = i.
        b2 = '0;
        for (int i = 0; i < 16; i++) b2[i*32 +: 32] = 32'(i);
        issue(2'd2, 2'd2, 2'd0, 1'b0, VL_W'(16), b2, VLEN'(10), aa);
        drain();

        // vl masking, vl=0 and vl clamping with wrap.
        issue(2'd0, 2'd0, 2'd0, 1'b0, VL_W'(3), {64{8'h7F}}, VLEN'(8'h7F), aa);
        issue(2'd0, 2'd0, 2'd0, 1'b0, VL_W'(0), {64{8'h7F}}, VLEN'(8'h7F), aa);
        issue(2'd0, 2'd0, 2'd0, 1'b0, VL_W'(200), {64{8'h7F}}, VLEN'(8'h7F), aa);
        drain();

        // Signedness of max/min.
        b2 = rand_grp();
        b2[7:0] = 8'h80;
        b2[15:8] = 8'h7F;
        issue(2'd0, 2'd0, 2'd1, 1'b1, VL_W'(2), b2, '0, aa);
        issue(2'd0, 2'd0, 2'd1, 1'b0, VL_W'(2), b2, '0, aa);
        issue(2'd0, 2'd0, 2'd2, 1'b1, VL_W'(2), b2, '0, aa);
        issue(2'd1, 2'd1, 2'd2, 1'b0, VL_W'(9), rand_grp(), rand_grp()[VLEN-1:0], aa);
        drain();

        // Held result under backpressure; a new request must not be taken.
        force_ready = 1'b0;
        issue(2'd0, 2'd0, 2'd0, 1'b0, VL_W'(16), {64{8'h01}}, VLEN'(8'h05), aa);
        t = 0;
        while (!out_valid && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (!out_valid) begin
            checks++;
            failures++;
            $display("FAIL backpressure_wait: out_valid=0 after %0d cycles, expected 1", t);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            sew = 2'd2; lmul_log2 = 2'd1; op = 2'd1; vl = VL_W'(5);
            vs2_bus = rand_grp(); vd_old = '1;
            in_valid = 1'b1;
        end
        @(negedge clk);
        in_valid = 1'b0;
        force_ready = 1'b1;
        drain();

        // Illegal requests.
        issue(2'd3, 2'd0, 2'd0, 1'b0, VL_W'(4), rand_grp(), rand_grp()[VLEN-1:0], rand_grp()[VLEN-1:0]);
        issue(2'd0, 2'd0, 2'd3, 1'b1, VL_W'(4), rand_grp(), rand_grp()[VLEN-1:0], rand_grp()[VLEN-1:0]);
        issue(2'd1, 2'd3, 2'd1, 1'b0, VL_W'(60), rand_grp(), rand_grp()[VLEN-1:0], rand_grp()[VLEN-1:0]);
        drain();

        // Reset while a four-register request is accumulating.
        issue(2'd0, 2'd2, 2'd0, 1'b0, VL_W'(64), rand_grp(), rand_grp()[VLEN-1:0], rand_grp()[VLEN-1:0]);
        #1;
        rst = 1'b1;
        #1;
        exp_q.delete();
        chk("midrst_out_valid", VLEN'(out_valid), '0);
        chk("midrst_vd_bus", vd_bus, '0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midrst_in_ready", VLEN'(in_ready), VLEN'(1));
        issue(2'd1, 2'd2, 2'd0, 1'b0, VL_W'(30), rand_grp(), rand_grp()[VLEN-1:0], rand_grp()[VLEN-1:0]);
        drain();

        // Randomised traffic with random consumer stalls.
        rand_ready = 1'b1;
        for (int n = 0; n < 250; n++) begin
            logic [1:0] s, l, o;
            s = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            l = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            o = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            issue(s, l, o, 1'($urandom), VL_W'($urandom_range(0, 127)),
                  rand_grp(), rand_grp()[VLEN-1:0], rand_grp()[VLEN-1:0]);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
        end
        rand_ready = 1'b0;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
